// File: rtl/ann_mac_engine_if.sv
// Controller/buffer-side signal bundle for one neuron MAC engine.
// slave = engine side, master = controller/buffer side.
interface ann_mac_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic                     reset_accum;
    logic                     coeff_ready;
    logic [ADDR_W-1:0]        max_input;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] pixel_in;
    logic signed [DATA_W-1:0] coef_in;
    logic                     busy;
    logic                     n_start_done;
    logic [DATA_W-1:0]        neuron_out;
    logic                     clamp_flag;

    modport slave (
        input  reset_accum, coeff_ready, max_input, pixel_in, coef_in,
        output rd_en, rd_addr, busy, n_start_done, neuron_out, clamp_flag
    );

    modport master (
        output reset_accum, coeff_ready, max_input, pixel_in, coef_in,
        input  rd_en, rd_addr, busy, n_start_done, neuron_out, clamp_flag
    );
endinterface

// File: rtl/ann_mac_engine.sv
// Single-neuron MAC sequencer: streams pixel/coef pairs, accumulates,
// then shifts, ReLUs and clamps the sum into an 8-bit result.
module ann_mac_engine #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 7,
    parameter int ACC_W     = 24,
    parameter int FRAC_BITS = 4
) (
    input logic              clk,
    input logic              n_rst,
    ann_mac_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int MAX_POS = (1 << (DATA_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX_POS);

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        idx, max_q, rd_addr_q;
    logic                     valid_d, issue;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc, acc_sum, fin, r;
    logic [DATA_W-1:0]        out_nxt, neuron_out_q;
    logic                     clamp_nxt, clamp_q;

    assign prod    = $signed(bus.pixel_in) * $signed(bus.coef_in);
    assign acc_sum = valid_d ? acc + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod}) : acc;
    // Result loaded on the edge entering DONE, so it includes the product accumulated on that same edge.
    assign fin     = bus.reset_accum ? '0 : acc_sum;
    assign r       = fin >>> FRAC_BITS;

    always_comb begin
        out_nxt   = '0;
        clamp_nxt = 1'b0;
        if (r < 0) begin
            out_nxt = '0;
        end else if (r >= MAX_S) begin
            out_nxt   = MAX_S[DATA_W-1:0];
            clamp_nxt = (r > MAX_S);
        end else begin
            out_nxt = r[DATA_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:  state_nxt = IDLE;
            RUN: begin
                issue = bus.coeff_ready;
                if (bus.coeff_ready && idx == max_q - ADDR_W'(1))
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.reset_accum)
            state_nxt = (bus.max_input == '0) ? DONE : RUN;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            idx          <= '0;
            max_q        <= '0;
            rd_addr_q    <= '0;
            valid_d      <= 1'b0;
            acc          <= '0;
            neuron_out_q <= '0;
            clamp_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue)
                rd_addr_q <= idx;
            if (bus.reset_accum) begin
                acc     <= '0;
                idx     <= '0;
                valid_d <= 1'b0;
                max_q   <= bus.max_input;
            end else begin
                acc     <= acc_sum;
                valid_d <= issue;
                if (issue)
                    idx <= idx + ADDR_W'(1);
            end
            if (state_nxt == DONE) begin
                neuron_out_q <= out_nxt;
                clamp_q      <= clamp_nxt;
            end
        end
    end

    assign bus.rd_en        = issue;
    assign bus.rd_addr      = issue ? idx : rd_addr_q;
    assign bus.busy         = (state == RUN) || (state == DRAIN);
    assign bus.n_start_done = (state == DONE);
    assign bus.neuron_out   = neuron_out_q;
    assign bus.clamp_flag   = clamp_q;
endmodule
